// File: rtl/hs_pkg.sv
// Shared constants and helpers for the tx3 -> rx3 handshake path.
package hs_pkg;

  localparam int unsigned HS_DW = 32;
  localparam int unsigned HS_CW = 16;

  // Ceiling log2 for sizing pointers; clog2(1) = 0.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(n)) r = 32'(i + 1);
    end
    return r;
  endfunction

endpackage

// File: rtl/hs_ram_2p.sv
// DEPTH x DW storage: one synchronous write port, one asynchronous read port.
module hs_ram_2p
  import hs_pkg::*;
#(
  parameter int unsigned DW    = HS_DW,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data_c
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data_c = mem[rd_addr];

endmodule

// File: rtl/hs_elastic_buf.sv
// Elastic valid/ready buffer between tx3 and rx3; every handshake output comes
// straight from a flop, so neither side sees a combinational path to the other.
module hs_elastic_buf
  import hs_pkg::*;
#(
  parameter int unsigned DW    = HS_DW,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = clog2(DEPTH),
  parameter int unsigned CW    = HS_CW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] s_data,
  input  logic          s_valid,
  output logic          s_ready,
  output logic [DW-1:0] m_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [AW:0]   level,
  output logic [CW-1:0] in_beats,
  output logic [CW-1:0] out_beats
);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr_nxt;
  logic [AW-1:0] rd_ptr_nxt;
  logic [AW:0]   level_nxt;
  logic          push;
  logic          pop;
  logic          bypass;
  logic          load;
  logic [DW-1:0] rd_data_c;
  logic [DW-1:0] m_data_nxt;

  // Next-state: the output register always holds the entry at the new head.
  always_comb begin
    push       = s_valid & s_ready;
    pop        = m_valid & m_ready;
    level_nxt  = level + (AW+1)'(push) - (AW+1)'(pop);
    wr_ptr_nxt = wr_ptr + AW'(push);
    rd_ptr_nxt = rd_ptr + AW'(pop);
    // Nothing older remains after this pop, so the incoming beat becomes the head.
    bypass     = push && ((level - (AW+1)'(pop)) == '0);
    // Head changes only on a pop or when filling from empty; otherwise hold.
    load       = (level_nxt != '0) && (pop || (level == '0));
    m_data_nxt = bypass ? s_data : rd_data_c;
  end

  hs_ram_2p #(
    .DW    (DW),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk       (clk),
    .wr_en     (push),
    .wr_addr   (wr_ptr),
    .wr_data   (s_data),
    .rd_addr   (rd_ptr_nxt),
    .rd_data_c (rd_data_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_ready   <= 1'b0;
      m_valid   <= 1'b0;
      m_data    <= '0;
      level     <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      in_beats  <= '0;
      out_beats <= '0;
    end else begin
      s_ready   <= level_nxt < (AW+1)'(DEPTH);
      m_valid   <= level_nxt != '0;
      level     <= level_nxt;
      wr_ptr    <= wr_ptr_nxt;
      rd_ptr    <= rd_ptr_nxt;
      in_beats  <= in_beats + CW'(push);
      out_beats <= out_beats + CW'(pop);
      if (load) m_data <= m_data_nxt;
    end
  end

endmodule

// File: tb/tb_hs_elastic_buf.sv
// Directed bench for hs_elastic_buf with a queue model checked every clock.
module tb_hs_elastic_buf;

  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW    = 2;
  localparam int unsigned CW    = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [AW:0]   level;
  logic [CW-1:0] in_beats;
  logic [CW-1:0] out_beats;

  int            n_asserts = 0;
  int            n_fail = 0;

  logic [DW-1:0] q[$];
  logic [DW-1:0] last_data;
  logic          rdy_ok;
  logic [CW-1:0] in_cnt;
  logic [CW-1:0] out_cnt;
  int            tot_in;
  logic          mr_pipe;

  hs_elastic_buf #(
    .DW    (DW),
    .DEPTH (DEPTH),
    .AW    (AW),
    .CW    (CW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_data    (s_data),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .level     (level),
    .in_beats  (in_beats),
    .out_beats (out_beats)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    logic [DW-1:0] exp_data;
    exp_data  = (q.size() != 0) ? q[0] : last_data;
    last_data = exp_data;
    chk("s_ready",   64'(s_ready),   64'(rdy_ok && (q.size() < DEPTH)));
    chk("m_valid",   64'(m_valid),   64'(q.size() != 0));
    chk("m_data",    64'(m_data),    64'(exp_data));
    chk("level",     64'(level),     64'(q.size()));
    chk("in_beats",  64'(in_beats),  64'(in_cnt));
    chk("out_beats", 64'(out_beats), 64'(out_cnt));
  endtask

  // One clock: drive inputs now, predict the handshake, check after the edge.
  task automatic cyc(input logic sv, input logic [DW-1:0] sd, input logic mr);
    logic push_m;
    logic pop_m;
    s_valid = sv;
    s_data  = sd;
    m_ready = mr;
    push_m  = sv && rdy_ok && (q.size() < DEPTH);
    pop_m   = mr && (q.size() != 0);
    @(posedge clk);
    #1;
    if (pop_m) begin
      void'(q.pop_front());
      out_cnt++;
    end
    if (push_m) begin
      q.push_back(sd);
      in_cnt++;
      tot_in++;
    end
    rdy_ok = 1'b1;
    check_model();
  endtask

  task automatic do_reset();
    s_valid = 1'b0;
    m_ready = 1'b0;
    s_data  = '0;
    rst_n   = 1'b0;
    #1;
    q.delete();
    in_cnt    = '0;
    out_cnt   = '0;
    tot_in    = 0;
    last_data = '0;
    rdy_ok    = 1'b0;
    chk("rst_s_ready",   64'(s_ready),   64'd0);
    chk("rst_m_valid",   64'(m_valid),   64'd0);
    chk("rst_level",     64'(level),     64'd0);
    chk("rst_m_data",    64'(m_data),    64'd0);
    chk("rst_in_beats",  64'(in_beats),  64'd0);
    chk("rst_out_beats", 64'(out_beats), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("rel_s_ready_low", 64'(s_ready), 64'd0);
  endtask

  task automatic drain();
    for (int k = 0; k < 16 && q.size() != 0; k++) cyc(1'b0, '0, 1'b1);
    chk("drain_m_valid", 64'(m_valid), 64'd0);
    chk("drain_level",   64'(level),   64'd0);
  endtask

  initial begin
    do_reset();

    // Reset mid-run with three beats stored.
    cyc(1'b1, 32'h11, 1'b0);
    chk("t1_first_edge_no_accept", 64'(level), 64'd0);
    chk("t1_s_ready_up", 64'(s_ready), 64'd1);
    cyc(1'b1, 32'h11, 1'b0);
    cyc(1'b1, 32'h12, 1'b0);
    cyc(1'b1, 32'h13, 1'b0);
    chk("t1_level3", 64'(level), 64'd3);
    #3;
    do_reset();
    cyc(1'b1, 32'h55, 1'b0);
    chk("t1_rel_s_ready", 64'(s_ready), 64'd1);
    chk("t1_rel_level", 64'(level), 64'd0);

    // Streaming 0..99 at full rate.
    for (int i = 0; i < 100; i++) begin
      cyc(1'b1, DW'(i), 1'b1);
      if (i == 0) begin
        chk("t2_latency_valid", 64'(m_valid), 64'd1);
        chk("t2_latency_data", 64'(m_data), 64'd0);
      end
    end
    drain();
    chk("t2_hold_last", 64'(m_data), 64'd99);

    // Fill to DEPTH, fifth beat held upstream, then drain in order.
    cyc(1'b1, 32'hA0, 1'b0);
    cyc(1'b1, 32'hA1, 1'b0);
    cyc(1'b1, 32'hA2, 1'b0);
    cyc(1'b1, 32'hA3, 1'b0);
    chk("t3_full_level", 64'(level), 64'd4);
    chk("t3_full_s_ready", 64'(s_ready), 64'd0);
    cyc(1'b1, 32'hA4, 1'b0);
    chk("t3_blocked_level", 64'(level), 64'd4);
    chk("t3_head_a0", 64'(m_data), 64'hA0);
    cyc(1'b1, 32'hA4, 1'b1);
    chk("t3_pop_a1", 64'(m_data), 64'hA1);
    chk("t3_pop_level", 64'(level), 64'd3);
    chk("t3_ready_back", 64'(s_ready), 64'd1);
    cyc(1'b1, 32'hA4, 1'b1);
    chk("t3_pushpop_a2", 64'(m_data), 64'hA2);
    chk("t3_pushpop_level", 64'(level), 64'd3);
    cyc(1'b0, '0, 1'b1);
    chk("t3_a3", 64'(m_data), 64'hA3);
    cyc(1'b0, '0, 1'b1);
    chk("t3_a4", 64'(m_data), 64'hA4);
    cyc(1'b0, '0, 1'b1);
    chk("t3_empty_valid", 64'(m_valid), 64'd0);
    chk("t3_empty_hold", 64'(m_data), 64'hA4);
    cyc(1'b0, '0, 1'b1);
    chk("t3_ready_ignored_level", 64'(level), 64'd0);

    // Backpressure: m_ready toggling each clock, random data.
    for (int i = 0; i < 40; i++) cyc(1'b1, $urandom, logic'(i[0]));
    drain();

    // Late-ready rx3: m_ready from a one-flop delay, driven 2 units after the edge.
    do_reset();
    mr_pipe = 1'b0;
    for (int k = 0; k < 6000 && in_cnt < 16'd1000; k++) begin
      #1;
      cyc($urandom_range(0, 3) != 0, $urandom, mr_pipe);
      mr_pipe = logic'($urandom_range(0, 1));
    end
    drain();
    chk("t5_in_beats", 64'(in_beats), 64'd1000);
    chk("t5_out_beats", 64'(out_beats), 64'd1000);

    // Counter wrap: 2^CW beats return both counters to zero.
    do_reset();
    for (int k = 0; k < 70000 && tot_in < 65536; k++) cyc(1'b1, DW'(k), 1'b1);
    drain();
    chk("t6_in_wrap", 64'(in_beats), 64'd0);
    chk("t6_out_wrap", 64'(out_beats), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
